// File: rtl/cpu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// typedefs: shared types for the VeriRisc instruction sequencer.
//   opcode_t        : IR opcode encoding (HLT=0 .. JMP=7)
//   state_t         : 8-phase fetch/execute states, numbered in transition order
//   cpu_seq_ctrl_t  : bundle of the eight datapath control strobes
//   next_state()    : successor of a state in the fixed phase order
// -----------------------------------------------------------------------------
package typedefs;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  typedef struct packed {
    logic mem_rd;
    logic load_ir;
    logic halt;
    logic inc_pc;
    logic load_ac;
    logic load_pc;
    logic mem_wr;
    logic data_e;
  } cpu_seq_ctrl_t;

  // States are numbered in transition order, so the successor is +1 mod 8.
  function automatic state_t next_state(input state_t s);
    return state_t'(3'(s + 3'd1));
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// -----------------------------------------------------------------------------
// cpu_sequencer_if: sequencer <-> datapath/memory signal bundle.
//   Inputs to sequencer : opcode, zero, mem_ready, resume
//   Outputs             : ps, the eight control strobes, cycle_cnt, instr_cnt
//   master modport : the sequencer side
//   slave modport  : the datapath / environment side
// -----------------------------------------------------------------------------
interface cpu_sequencer_if
  import typedefs::*;
#(
  parameter int PERF_W = 16
);

  opcode_t           opcode;
  logic              zero;
  logic              mem_ready;
  logic              resume;
  state_t            ps;
  logic              mem_rd;
  logic              load_ir;
  logic              halt;
  logic              inc_pc;
  logic              load_ac;
  logic              load_pc;
  logic              mem_wr;
  logic              data_e;
  logic [PERF_W-1:0] cycle_cnt;
  logic [PERF_W-1:0] instr_cnt;

  modport master (
    input  opcode, zero, mem_ready, resume,
    output ps, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e,
    output cycle_cnt, instr_cnt
  );

  modport slave (
    output opcode, zero, mem_ready, resume,
    input  ps, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e,
    input  cycle_cnt, instr_cnt
  );

endinterface

// File: rtl/cpu_sequencer_decode.sv
// -----------------------------------------------------------------------------
// cpu_seq_decode: purely combinational strobe decode.
//   i_ps     : present state
//   i_opcode : current IR opcode
//   i_zero   : accumulator-zero flag
//   i_halted : sticky halt flag from the sequencer
//   o_ctrl   : the eight control strobes
// -----------------------------------------------------------------------------
module cpu_seq_decode
  import typedefs::*;
(
  input  state_t        i_ps,
  input  opcode_t       i_opcode,
  input  logic          i_zero,
  input  logic          i_halted,
  output cpu_seq_ctrl_t o_ctrl
);

  logic w_aluop;
  assign w_aluop = i_opcode inside {ADD, AND, XOR, LDA};

  always_comb begin
    // NOTE: every strobe gets a default before the case so no path leaves a
    // value unassigned, which would infer a latch.
    o_ctrl = '0;
    case (i_ps)
      INST_ADDR: ;
      INST_FETCH: o_ctrl.mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        o_ctrl.mem_rd  = 1'b1;
        o_ctrl.load_ir = 1'b1;
      end
      OP_ADDR: begin
        // While parked in a halt the PC must not run away.
        o_ctrl.inc_pc = ~i_halted;
        o_ctrl.halt   = (i_opcode == HLT) || i_halted;
      end
      OP_FETCH: o_ctrl.mem_rd = w_aluop;
      ALU_OP: begin
        o_ctrl.mem_rd  = w_aluop;
        o_ctrl.load_ac = w_aluop;
        o_ctrl.inc_pc  = (i_opcode == SKZ) && i_zero;
        o_ctrl.load_pc = (i_opcode == JMP);
        o_ctrl.data_e  = (i_opcode == STO);
      end
      STORE: begin
        o_ctrl.mem_rd  = w_aluop;
        o_ctrl.load_ac = w_aluop;
        o_ctrl.inc_pc  = (i_opcode == JMP);
        o_ctrl.load_pc = (i_opcode == JMP);
        o_ctrl.mem_wr  = (i_opcode == STO);
        o_ctrl.data_e  = (i_opcode == STO);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer: VeriRisc 8-phase instruction sequencer with sticky halt /
// resume, memory-ready stalling in INST_FETCH and OP_FETCH, and optional
// saturating performance counters.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : cpu_sequencer_if.master (opcode, zero, mem_ready, resume in;
//         ps, strobes, cycle_cnt, instr_cnt out)
// Parameter PERF_W (8..32): counter width.
// Macro CPU_SEQ_PERF_EN: build the counters; when undefined they read 0 and
// no counter flops exist.
// -----------------------------------------------------------------------------
module cpu_sequencer
  import typedefs::*;
#(
  parameter int PERF_W = 16
)(
  input  logic             clk,
  input  logic             rst,
  cpu_sequencer_if.master  bus
);

  state_t        r_ps;
  logic          r_halted;
  cpu_seq_ctrl_t w_ctrl;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values and simulation matches the synthesized hardware.
    if (rst) begin
      r_ps     <= INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      case (r_ps)
        INST_FETCH, OP_FETCH: begin
          if (bus.mem_ready) r_ps <= next_state(r_ps);
        end
        OP_ADDR: begin
          // A HLT parks here; only resume while parked releases it.
          if (r_halted) begin
            if (bus.resume) begin
              r_halted <= 1'b0;
              r_ps     <= OP_FETCH;
            end
          end else if (bus.opcode == HLT) begin
            r_halted <= 1'b1;
          end else begin
            r_ps <= OP_FETCH;
          end
        end
        default: r_ps <= next_state(r_ps);
      endcase
    end
  end

  cpu_seq_decode u_decode (
    .i_ps     (r_ps),
    .i_opcode (bus.opcode),
    .i_zero   (bus.zero),
    .i_halted (r_halted),
    .o_ctrl   (w_ctrl)
  );

  assign bus.ps      = r_ps;
  assign bus.mem_rd  = w_ctrl.mem_rd;
  assign bus.load_ir = w_ctrl.load_ir;
  assign bus.halt    = w_ctrl.halt;
  assign bus.inc_pc  = w_ctrl.inc_pc;
  assign bus.load_ac = w_ctrl.load_ac;
  assign bus.load_pc = w_ctrl.load_pc;
  assign bus.mem_wr  = w_ctrl.mem_wr;
  assign bus.data_e  = w_ctrl.data_e;

`ifdef CPU_SEQ_PERF_EN
  logic [PERF_W-1:0] r_cycle_cnt;
  logic [PERF_W-1:0] r_instr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (~&r_cycle_cnt) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      // STORE never stalls, so being in STORE means STORE -> INST_ADDR now.
      if ((r_ps == STORE) && ~&r_instr_cnt) r_instr_cnt <= r_instr_cnt + 1'b1;
    end
  end

  assign bus.cycle_cnt = r_cycle_cnt;
  assign bus.instr_cnt = r_instr_cnt;
`else
  assign bus.cycle_cnt = '0;
  assign bus.instr_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer: self-checking bench for cpu_sequencer.
// Directed per-cycle vector table, hand-written halt/reset sequences, then
// randomized stimulus against a phase-counting reference model.
// Strobe byte order: {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc,
// mem_wr, data_e}.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;
  import typedefs::*;

  localparam int          PW  = 8;
  localparam int unsigned SAT = (1 << PW) - 1;
`ifdef CPU_SEQ_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  cpu_sequencer_if #(.PERF_W(PW)) bus ();

  cpu_sequencer #(.PERF_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase 0..7 follows the spec's state order; counters are plain integers.
  int          m_phase;
  bit          m_halted;
  int unsigned m_cyc;
  int unsigned m_ret;

  always @(posedge clk) begin
    if (rst) begin
      m_phase  <= 0;
      m_halted <= 1'b0;
      m_cyc    <= 0;
      m_ret    <= 0;
    end else begin
      if (m_cyc < SAT) m_cyc <= m_cyc + 1;
      if (m_phase == 7 && m_ret < SAT) m_ret <= m_ret + 1;
      if ((m_phase == 1 || m_phase == 5) && !bus.mem_ready) begin
        m_phase <= m_phase;
      end else if (m_phase == 4 && m_halted) begin
        if (bus.resume) begin
          m_halted <= 1'b0;
          m_phase  <= 5;
        end
      end else if (m_phase == 4 && bus.opcode == HLT) begin
        m_halted <= 1'b1;
      end else begin
        m_phase <= (m_phase + 1) % 8;
      end
    end
  end

  // Each strobe written as "in which phases, under which opcode condition".
  function automatic logic [7:0] exp_strobes(input int ph, input opcode_t op,
                                              input bit z, input bit hlt);
    bit alu;
    bit s_rd, s_ir, s_h, s_inc, s_ac, s_pc, s_wr, s_de;
    alu   = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    s_rd  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    s_ir  = (ph == 2) || (ph == 3);
    s_h   = (ph == 4) && (op == HLT || hlt);
    s_inc = (ph == 4 && !hlt) || (ph == 6 && op == SKZ && z) || (ph == 7 && op == JMP);
    s_ac  = (ph >= 6) && alu;
    s_pc  = (ph >= 6) && (op == JMP);
    s_wr  = (ph == 7) && (op == STO);
    s_de  = (ph >= 6) && (op == STO);
    return {s_rd, s_ir, s_h, s_inc, s_ac, s_pc, s_wr, s_de};
  endfunction

  function automatic logic [7:0] dut_strobes();
    return {bus.mem_rd, bus.load_ir, bus.halt, bus.inc_pc,
            bus.load_ac, bus.load_pc, bus.mem_wr, bus.data_e};
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_cycle_cnt"}, 32'(bus.cycle_cnt), PERF_ON ? m_cyc : 32'd0);
    check({tag, "_instr_cnt"}, 32'(bus.instr_cnt), PERF_ON ? m_ret : 32'd0);
  endtask

  task automatic check_model();
    logic [7:0] s;
    s = dut_strobes();
    check("rnd_ps", 32'(bus.ps), 32'(m_phase));
    check("rnd_strobes", 32'(s), 32'(exp_strobes(m_phase, bus.opcode, bus.zero, m_halted)));
    check_counters("rnd");
    if (m_phase == 4 || m_phase == 6)
      check("legal_onehot0", 32'($onehot0({bus.inc_pc, bus.load_pc})), 32'd1);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic run_until(input int ph);
    for (int k = 0; k < 40 && int'(bus.ps) != ph; k++) cyc();
    check("reach_state", 32'(bus.ps), 32'(ph));
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    opcode_t    op;
    logic [2:0] zrr;   // {zero, mem_ready, resume}
    logic [2:0] ps;    // expected present state this cycle
    logic [7:0] stb;   // expected strobes this cycle
  } vec_t;

  vec_t tbl[$];

  task automatic add(input opcode_t op, input logic [2:0] zrr,
                     input logic [2:0] ps, input logic [7:0] stb);
    vec_t v;
    v.op = op; v.zrr = zrr; v.ps = ps; v.stb = stb;
    tbl.push_back(v);
  endtask

  initial begin
    // ADD: resume ignored when not halted; mem_ready ignored outside fetches.
    add(ADD, 3'b011, 3'd0, 8'h00);
    add(ADD, 3'b010, 3'd1, 8'h80);
    add(ADD, 3'b000, 3'd2, 8'hC0);
    add(ADD, 3'b010, 3'd3, 8'hC0);
    add(ADD, 3'b010, 3'd4, 8'h10);
    add(ADD, 3'b010, 3'd5, 8'h80);
    add(ADD, 3'b100, 3'd6, 8'h88);
    add(ADD, 3'b010, 3'd7, 8'h88);
    // JMP with a 3-cycle stall in INST_FETCH (4 cycles there).
    add(JMP, 3'b010, 3'd0, 8'h00);
    add(JMP, 3'b000, 3'd1, 8'h80);
    add(JMP, 3'b000, 3'd1, 8'h80);
    add(JMP, 3'b000, 3'd1, 8'h80);
    add(JMP, 3'b010, 3'd1, 8'h80);
    add(JMP, 3'b010, 3'd2, 8'hC0);
    add(JMP, 3'b010, 3'd3, 8'hC0);
    add(JMP, 3'b010, 3'd4, 8'h10);
    add(JMP, 3'b010, 3'd5, 8'h00);
    add(JMP, 3'b010, 3'd6, 8'h04);
    add(JMP, 3'b010, 3'd7, 8'h14);
    // SKZ zero=1 with a 1-cycle stall in OP_FETCH.
    add(SKZ, 3'b110, 3'd0, 8'h00);
    add(SKZ, 3'b110, 3'd1, 8'h80);
    add(SKZ, 3'b110, 3'd2, 8'hC0);
    add(SKZ, 3'b110, 3'd3, 8'hC0);
    add(SKZ, 3'b110, 3'd4, 8'h10);
    add(SKZ, 3'b100, 3'd5, 8'h00);
    add(SKZ, 3'b110, 3'd5, 8'h00);
    add(SKZ, 3'b110, 3'd6, 8'h10);
    add(SKZ, 3'b110, 3'd7, 8'h00);
    // SKZ zero=0: no skip.
    add(SKZ, 3'b010, 3'd0, 8'h00);
    add(SKZ, 3'b010, 3'd1, 8'h80);
    add(SKZ, 3'b010, 3'd2, 8'hC0);
    add(SKZ, 3'b010, 3'd3, 8'hC0);
    add(SKZ, 3'b010, 3'd4, 8'h10);
    add(SKZ, 3'b010, 3'd5, 8'h00);
    add(SKZ, 3'b010, 3'd6, 8'h00);
    add(SKZ, 3'b010, 3'd7, 8'h00);
    // STO.
    add(STO, 3'b010, 3'd0, 8'h00);
    add(STO, 3'b010, 3'd1, 8'h80);
    add(STO, 3'b010, 3'd2, 8'hC0);
    add(STO, 3'b010, 3'd3, 8'hC0);
    add(STO, 3'b010, 3'd4, 8'h10);
    add(STO, 3'b010, 3'd5, 8'h00);
    add(STO, 3'b010, 3'd6, 8'h01);
    add(STO, 3'b010, 3'd7, 8'h03);

    // ---------------- reset (resume asserted too: reset wins) ----------------
    rst = 1'b1;
    bus.opcode = ADD; bus.zero = 1'b0; bus.mem_ready = 1'b1; bus.resume = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_ps", 32'(bus.ps), 32'(INST_ADDR));
    check("reset_strobes", 32'(dut_strobes()), 32'h00);
    check_counters("reset");
    rst = 1'b0; bus.resume = 1'b0;

    // ---------------- table ----------------
    foreach (tbl[i]) begin
      bus.opcode = tbl[i].op;
      {bus.zero, bus.mem_ready, bus.resume} = tbl[i].zrr;
      #1;
      check($sformatf("vec%0d_ps", i), 32'(bus.ps), 32'(tbl[i].ps));
      check($sformatf("vec%0d_strobes", i), 32'(dut_strobes()), 32'(tbl[i].stb));
      check_counters($sformatf("vec%0d", i));
      cyc();
    end

    // ---------------- HLT and resume ----------------
    bus.zero = 1'b0; bus.mem_ready = 1'b1; bus.resume = 1'b0;
    do_reset();
    bus.opcode = HLT;
    run_until(4);
    #1;
    check("hlt_first_strobes", 32'(dut_strobes()), 32'h30);
    cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("hlt_hold_ps", 32'(bus.ps), 32'(OP_ADDR));
      check("hlt_hold_strobes", 32'(dut_strobes()), 32'h20);
      cyc();
    end
    bus.resume = 1'b1;
    cyc();
    bus.resume = 1'b0;
    #1;
    check("resume_ps", 32'(bus.ps), 32'(OP_FETCH));
    check("resume_halt", 32'(bus.halt), 32'd0);

    // Halt again, then rst together with resume: reset wins, halt cleared.
    run_until(4);
    cyc();
    #1;
    check("rehalt_ps", 32'(bus.ps), 32'(OP_ADDR));
    bus.resume = 1'b1; rst = 1'b1;
    cyc();
    bus.resume = 1'b0; rst = 1'b0;
    #1;
    check("rst_vs_resume_ps", 32'(bus.ps), 32'(INST_ADDR));
    check("rst_vs_resume_strobes", 32'(dut_strobes()), 32'h00);
    bus.opcode = ADD;
    run_until(4);
    #1;
    check("halt_cleared_strobes", 32'(dut_strobes()), 32'h10);

    // ---------------- reset during ALU_OP ----------------
    run_until(6);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("rst_aluop_ps", 32'(bus.ps), 32'(INST_ADDR));
    check("rst_aluop_strobes", 32'(dut_strobes()), 32'h00);
    check("rst_aluop_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
    check("rst_aluop_instr_cnt", 32'(bus.instr_cnt), 32'd0);

    // ---------------- randomized run against the model ----------------
    // The long reset-free tail drives both 8-bit counters into saturation.
    for (int i = 0; i < 5500; i++) begin
      bus.opcode    = opcode_t'($urandom_range(0, 7));
      bus.zero      = 1'($urandom_range(0, 1));
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      bus.resume    = ($urandom_range(0, 9) < 3);
      rst           = (i < 1500) && ($urandom_range(0, 49) == 0);
      #1;
      check_model();
      cyc();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction sequencer for the VeriRisc CPU. It drives the control strobes that the datapath consumes and that the formal CPU property set checks. It steps an 8-phase fetch/execute cycle and decodes `opcode`, `zero` and the memory handshake into those strobes. It adds three things on top of the basic cycle:
- a sticky halt with resume,
- memory-ready stalling,
- optional performance counters.

## Interface
Parameters:
- `PERF_W`, default 16: width of the performance counters. Legal range is 8–32.

Ports:
- `clk` input 1: the single clock. Everything updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `opcode` input `opcode_t` (3): current IR opcode.
- `zero` input 1: accumulator-zero flag from the ALU.
- `mem_ready` input 1: memory read data valid. Sampled in INST_FETCH and OP_FETCH.
- `resume` input 1: single-cycle pulse that releases a halt.
- `ps` output `state_t` (3): present state.
- `mem_rd` output 1: memory read strobe.
- `load_ir` output 1: IR load.
- `halt` output 1: halt indication.
- `inc_pc` output 1: PC increment.
- `load_ac` output 1: accumulator load.
- `load_pc` output 1: PC load.
- `mem_wr` output 1: memory write.
- `data_e` output 1: accumulator drive onto the data bus.
- `cycle_cnt` output PERF_W: cycles since reset.
- `instr_cnt` output PERF_W: instructions retired.

## Operation
- The state order is INST_ADDR → INST_FETCH → INST_LOAD → IDLE → OP_ADDR → OP_FETCH → ALU_OP → STORE → INST_ADDR.
- ALUOP means `opcode` is one of ADD, AND, XOR or LDA.
- Outputs are a combinational decode of `ps`, `opcode`, `zero` and `halted`. Any strobe not listed for a state is 0.

| State | Strobes |
|---|---|
| INST_ADDR | none |
| INST_FETCH | mem_rd |
| INST_LOAD | mem_rd, load_ir |
| IDLE | mem_rd, load_ir |
| OP_ADDR | inc_pc; halt = (opcode == HLT) \|\| halted |
| OP_FETCH | mem_rd = ALUOP |
| ALU_OP | mem_rd = ALUOP; load_ac = ALUOP; inc_pc = (SKZ && zero); load_pc = JMP; data_e = STO |
| STORE | mem_rd = ALUOP; load_ac = ALUOP; inc_pc = JMP; load_pc = JMP; mem_wr = STO; data_e = STO |

Halt:
- In OP_ADDR with `opcode == HLT` and `halted == 0`, the sequencer emits `inc_pc=1`, `halt=1` and sets `halted`. The FSM holds in OP_ADDR.
- While `halted=1`, only `halt=1` is driven and `inc_pc=0`, so the PC does not run away.
- `resume=1` while halted clears `halted` and moves to OP_FETCH on the same edge.
- `resume` is ignored when the sequencer is not halted.

Stall:
- In INST_FETCH and OP_FETCH the FSM advances only when `mem_ready=1`. Otherwise it holds, and all strobes hold their state decode.
- No other state samples `mem_ready`.

Legality:
- `load_pc` and `inc_pc` are never both 1, except for JMP in STORE.
- In OP_ADDR and ALU_OP the pair {inc_pc, load_pc} is onehot0.

Reset:
- `rst=1` at an edge forces `ps=INST_ADDR`, `halted=0` and both counters to 0. This takes priority over `resume`, `mem_ready` and any in-flight state.
- The output values in reset are the INST_ADDR decode: every strobe is 0.

## Timing
- Each state occupies one cycle unless it is stalled or halted. An unstalled instruction takes exactly 8 cycles.
- Strobes are valid combinationally in the cycle of their state. The datapath consumes them at the end of that cycle.
- The state register is the only sequential element of the FSM. Outputs have zero latency with respect to `ps`.
- A stall of N cycles with `mem_ready=0` lengthens INST_FETCH or OP_FETCH to N+1 cycles.
- After a HLT, `halt` stays 1 from the first OP_ADDR cycle until the cycle after `resume` is sampled.
- When `resume` and `rst` are asserted together, reset wins.

## Configuration
`CPU_SEQ_PERF_EN` selects whether the counters are built. The ports exist in both cases.

With the macro defined:
- `cycle_cnt` increments on every non-reset edge and saturates at all-ones.
- `instr_cnt` increments on each STORE → INST_ADDR transition and saturates.
- A halted sequencer still counts cycles but retires nothing.

Without the macro:
- `cycle_cnt` and `instr_cnt` are tied to 0.
- No counter flops are inferred.

## Structure
- `opcode_t` (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7) and `state_t` (INST_ADDR=0 … STORE=7, in transition order) stay in the shared `typedefs` package.
- A `cpu_seq_ctrl_t` struct bundling the eight strobes is added to `typedefs`.
- One sub-module, `cpu_seq_decode`, holds the purely combinational `(ps, opcode, zero, halted) → cpu_seq_ctrl_t` decode. The top level holds the state register, the halt flag and the counters.

## Test plan
- **Reset and ADD.** Reset, then `opcode=ADD`, `mem_ready=1` → `ps` cycles 0..7 in 8 cycles, `load_ac=1` in ALU_OP and STORE, `instr_cnt=1` after the first wrap (macro on).
- **JMP.** `opcode=JMP` → `load_pc=1` in ALU_OP. In STORE, `load_pc=1` and `inc_pc=1` together. `load_pc=0` in OP_ADDR and OP_FETCH.
- **SKZ.** `opcode=SKZ`, `zero=1` → `inc_pc=1` in ALU_OP. Repeat with `zero=0` → `inc_pc=0` in ALU_OP.
- **STO.** `opcode=STO` → `data_e=1` in ALU_OP and STORE, `mem_wr=1` only in STORE, `load_ac=0` throughout.
- **HLT and resume.** `opcode=HLT` → OP_ADDR shows `inc_pc=1`, `halt=1`. Then 5 cycles hold OP_ADDR with `inc_pc=0`, `halt=1`. A `resume` pulse → OP_FETCH on the next cycle with `halt=0`.
- **Stall, then reset.** `mem_ready=0` for 3 cycles in INST_FETCH → `ps` holds for 4 cycles with `mem_rd=1`. Asserting `rst` during ALU_OP → next `ps=INST_ADDR`, all strobes 0, counters 0.
